// File: rtl/rr_decode_arbiter.sv
// rtl/rr_decode_arbiter.sv - round-robin arbiter over 8 requesters with registered index and one-hot grant
module rr_decode_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic       gnt_valid,
    output logic [2:0] gnt_idx,
    output logic [7:0] gnt_onehot,
    output logic       timeout
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [2:0] ptr_q, ptr_d;
    logic [7:0] hold_q, hold_d;
    logic [7:0] onehot_q, onehot_d;
    logic       tmo_q, tmo_d;

    logic       pick_found;
    logic [2:0] pick_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= 3'd0;
            ptr_q    <= 3'd0;
            hold_q   <= 8'd0;
            onehot_q <= 8'h00;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            ptr_q    <= ptr_d;
            hold_q   <= hold_d;
            onehot_q <= onehot_d;
            tmo_q    <= tmo_d;
        end
    end

    // Scan from the farthest offset down so the nearest set bit after ptr wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = ptr_q;
        for (int i = 7; i >= 0; i--) begin
            if (req[ptr_q + 3'(i)]) begin
                pick_found = 1'b1;
                pick_idx   = ptr_q + 3'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        ptr_d    = ptr_q;
        hold_d   = hold_q;
        onehot_d = onehot_q;
        tmo_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d  = GRANT;
                    idx_d    = pick_idx;
                    onehot_d = 8'h01 << pick_idx;
                    hold_d   = 8'd0;
                end
            end
            GRANT: begin
                hold_d = (hold_q == 8'hFF) ? hold_q : hold_q + 8'd1;
                // A requester dropping on the limit edge counts as a normal release.
                if (!req[idx_q] || hold_q == HOLD_LAST) begin
                    state_d  = IDLE;
                    onehot_d = 8'h00;
                    ptr_d    = idx_q + 3'd1;
                    tmo_d    = req[idx_q];
                end
            end
            default: begin
                state_d  = IDLE;
                onehot_d = 8'h00;
            end
        endcase
    end

    always_comb begin
        gnt_valid  = (state_q == GRANT);
        gnt_idx    = idx_q;
        gnt_onehot = onehot_q;
        timeout    = tmo_q;
    end

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// tb/tb_rr_decode_arbiter.sv - vector table and scoreboard bench for rr_decode_arbiter
module tb_rr_decode_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       gnt_valid;
    logic [2:0] gnt_idx;
    logic [7:0] gnt_onehot;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic       v;
        logic [2:0] idx;
        logic       tmo;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    rr_decode_arbiter #(.MAX_HOLD(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx),
        .gnt_onehot (gnt_onehot),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [7:0] q, input logic v, input logic [2:0] i, input logic t);
        vec_t x;
        x.rst = r;
        x.req = q;
        x.v   = v;
        x.idx = i;
        x.tmo = t;
        vecs.push_back(x);
    endtask

    initial begin
        vec_t e;
        int   n_wait;
        int   len;

        rst = 1'b1;
        req = 8'h00;

        // reset with all requests pending, then first grant goes to idx 0
        add(1, 8'hFF, 0, 0, 0);
        add(1, 8'hFF, 0, 0, 0);
        add(0, 8'hFF, 1, 0, 0);
        add(0, 8'hFE, 0, 0, 0);

        // rotation and wrap between requesters 0 and 7, 3-cycle grants
        add(1, 8'h00, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            add(0, 8'h81, 1, 0, 0);
            add(0, 8'h81, 1, 0, 0);
            add(0, 8'h81, 1, 0, 0);
            add(0, 8'h80, 0, 0, 0);
            add(0, 8'h81, 1, 7, 0);
            add(0, 8'h81, 1, 7, 0);
            add(0, 8'h81, 1, 7, 0);
            add(0, 8'h01, 0, 7, 0);
        end

        // forced release after 16 cycles, then re-grant after one idle cycle
        add(1, 8'h00, 0, 0, 0);
        for (int k = 0; k < 16; k++) add(0, 8'h08, 1, 3, 0);
        add(0, 8'h08, 0, 3, 1);
        add(0, 8'h08, 1, 3, 0);
        add(0, 8'h00, 0, 3, 0);

        // request drops on the same edge the limit is reached
        add(1, 8'h00, 0, 0, 0);
        for (int k = 0; k < 16; k++) add(0, 8'h20, 1, 5, 0);
        add(0, 8'h00, 0, 5, 0);
        add(0, 8'h00, 0, 5, 0);

        // full load fairness
        add(1, 8'h00, 0, 0, 0);
        for (int k = 0; k < 9; k++) begin
            logic [7:0] bit_k;
            bit_k = 8'h01 << (k % 8);
            add(0, 8'hFF, 1, 3'(k % 8), 0);
            add(0, 8'hFF & ~bit_k, 0, 3'(k % 8), 0);
        end

        // reset during the 5th cycle of a grant to idx 6
        add(1, 8'h00, 0, 0, 0);
        for (int k = 0; k < 5; k++) add(0, 8'h40, 1, 6, 0);
        add(1, 8'h40, 0, 0, 0);
        add(0, 8'h40, 1, 6, 0);
        add(0, 8'h00, 0, 6, 0);

        for (int n = 0; n < vecs.size(); n++) begin
            @(negedge clk);
            rst = vecs[n].rst;
            req = vecs[n].req;
            exp_q.push_back(vecs[n]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            chk($sformatf("vec%0d gnt_valid", n), {7'd0, gnt_valid}, {7'd0, e.v});
            chk($sformatf("vec%0d gnt_idx", n), {5'd0, gnt_idx}, {5'd0, e.idx});
            chk($sformatf("vec%0d gnt_onehot", n), gnt_onehot, e.v ? (8'h01 << e.idx) : 8'h00);
            chk($sformatf("vec%0d timeout", n), {7'd0, timeout}, {7'd0, e.tmo});
        end

        // hand sequence: no combinational req path, then measure hold length with bounded waits
        @(negedge clk);
        rst = 1'b1;
        req = 8'h00;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
        req = 8'h08;
        #1;
        chk("comb_path gnt_valid", {7'd0, gnt_valid}, 8'd0);
        chk("comb_path gnt_onehot", gnt_onehot, 8'h00);
        n_wait = 0;
        while (!gnt_valid && n_wait < 4) begin
            @(posedge clk);
            #1;
            n_wait++;
        end
        chk("hold grant_latency", 8'(n_wait), 8'd1);
        len = 0;
        while (gnt_valid && len < 40) begin
            len++;
            @(posedge clk);
            #1;
        end
        chk("hold length", 8'(len), 8'd16);
        chk("hold timeout_pulse", {7'd0, timeout}, 8'd1);
        chk("hold idx_retained", {5'd0, gnt_idx}, 8'd3);
        @(posedge clk);
        #1;
        chk("hold regrant_valid", {7'd0, gnt_valid}, 8'd1);
        chk("hold timeout_cleared", {7'd0, timeout}, 8'd0);
        @(negedge clk);
        req = 8'h00;
        @(posedge clk);
        #1;
        chk("hold final_release", {7'd0, gnt_valid}, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_decode_arbiter.md
Name: rr_decode_arbiter

Overview:
- Round-robin arbiter that shares one 3-to-8 one-hot select resource (bus/peripheral select lines) among 8 requesters.
- Each cycle it picks at most one requester, holds the grant while that requester keeps its request asserted, and enforces a maximum hold time.
- Drives both the 3-bit grant index and the decoded one-hot grant, so downstream select logic sees a registered one-hot code.

Parameters:
- MAX_HOLD, 16, maximum consecutive cycles one grant may stay valid; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req  input  8  request vector; bit i = requester i; level-sensitive, held high while using the resource
- gnt_valid  output  1  a grant is active
- gnt_idx  output  3  index of granted requester; meaningful only when gnt_valid=1
- gnt_onehot  output  8  one-hot decode of gnt_idx (bit gnt_idx set) when gnt_valid=1, else 8'h00
- timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD

Behaviour:
- Reset: synchronous on rst=1 at a rising edge. gnt_valid=0, gnt_idx=3'd0, gnt_onehot=8'h00, timeout=0, priority pointer ptr=3'd0, hold counter=0, state=IDLE. Reset mid-grant drops the grant on the next edge with no timeout pulse.
- All outputs are registered; no combinational path from req to any output.
- States:
  - IDLE: gnt_valid=0. At an edge where req!=0, select the first set bit searching ptr, ptr+1, …, wrapping 7→0. Load gnt_idx, set gnt_valid=1, set gnt_onehot to the decoded bit, clear the hold counter, go to GRANT.
    - Latency: req rises at edge t, grant is visible after edge t+1.
    - If req=0, stay in IDLE.
  - GRANT: at each edge, the hold counter increments (saturating; width 8 bits).
    - If req[gnt_idx]=0: release. Next cycle gnt_valid=0, gnt_onehot=0, ptr=gnt_idx+1 (mod 8), go to IDLE, timeout=0.
    - Else if hold counter==MAX_HOLD-1: forced release. Same as above, but timeout=1 for exactly that one cycle.
    - Else stay in GRANT; outputs unchanged.
- Simultaneous release and limit (req drops on the same edge the limit is reached): treat as a normal release, timeout=0.
- gnt_valid is high for at most MAX_HOLD consecutive cycles. MAX_HOLD=1 yields single-cycle grants.
- At least one idle cycle (gnt_valid=0) separates consecutive grants, including back-to-back grants to different requesters.
- gnt_idx retains its last value while gnt_valid=0 (not cleared except by reset).
- Changes in other req bits during GRANT have no effect until the return to IDLE.
- A force-released requester that keeps req high is treated as a new request. Rotation guarantees every other pending requester is served first.
- ptr wraps 7+1→0.
- Invariant: gnt_onehot has popcount ≤1 and equals (gnt_valid ? 1<<gnt_idx : 0) every cycle.

Test Plan:
- Reset behaviour: assert rst 2 cycles with req=8'hFF → all outputs 0, and ptr=0 proven by the next grant going to idx 0. Deassert rst → first grant gnt_idx=0, gnt_onehot=8'h01, one cycle after the edge.
- Rotation and wrap: req=8'b1000_0001 constant, each grantee drops its req bit 3 cycles into its grant then reasserts it → grant order 0, 7, 0, 7. Each grant 3 cycles long, one idle cycle between grants, gnt_onehot alternates 8'h01 / 8'h80.
- Timeout: MAX_HOLD=16, only req[3]=1 held high → gnt_valid high exactly 16 cycles with gnt_idx=3, gnt_onehot=8'h08. timeout=1 on the first cycle gnt_valid=0, one idle cycle, then idx 3 is granted again.
- Simultaneous release/limit: req[5] drops on the same edge the hold counter reaches 15 → grant ends, timeout stays 0.
- Fairness under full load: req=8'hFF, each grantee drops its bit after 1 cycle → grants cycle through idx 0,1,…,7,0 with no index skipped or repeated.
- Reset mid-grant: rst=1 during the 5th cycle of a grant to idx 6 → next cycle gnt_valid=0, gnt_onehot=0, timeout=0. After release of rst with req=8'h40 → idx 6 granted (ptr=0, searching upward).
